// File: rtl/simon_round_seq_pkg.sv
// Shared SIMON definitions: word/index widths, mode encoding, round counts,
// sequencer state encoding and the watchdog limit used by simon_round_seq.
package simon_round_seq_pkg;

  localparam int unsigned SIMON_WORD_W        = 64;
  localparam int unsigned SIMON_KEY_IDX_W     = 7;
  localparam int unsigned SIMON_ROUNDS_64_128  = 44;
  localparam int unsigned SIMON_ROUNDS_128_128 = 68;
  localparam int unsigned SIMON_WD_W          = 5;

  // Last watchdog count before a timeout fires (31st cycle without response).
  localparam logic [SIMON_WD_W-1:0] SIMON_WD_LIMIT = SIMON_WD_W'(30);

  typedef enum logic {
    SIMON_MODE_64_128  = 1'b0,
    SIMON_MODE_128_128 = 1'b1
  } simon_mode_e;

  typedef enum logic [2:0] {
    ST_NOKEY = 3'd0,
    ST_KREQ  = 3'd1,
    ST_KWAIT = 3'd2,
    ST_READY = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic [SIMON_WORD_W-1:0] b1;
    logic [SIMON_WORD_W-1:0] b2;
  } simon_block_t;

  // Index of the last round (R-1) for a mode.
  function automatic logic [SIMON_KEY_IDX_W-1:0] simon_last_round(input simon_mode_e m);
    if (m == SIMON_MODE_128_128) return SIMON_KEY_IDX_W'(SIMON_ROUNDS_128_128 - 1);
    return SIMON_KEY_IDX_W'(SIMON_ROUNDS_64_128 - 1);
  endfunction

endpackage

// File: rtl/simon_key_index_ctr.sv
// Round counter and expanded-key index generator.
// Ports:
//   clock, reset   : clock, async active-high reset
//   i_load         : load counter with R-1 for i_mode, latch i_enc
//   i_dec          : decrement counter (one round finished)
//   i_enc          : 1 = encrypt (index counts up), 0 = decrypt (index counts down)
//   i_mode         : latched cipher mode, selects R
//   o_cnt_zero     : counter is zero (last round in flight)
//   o_key_idx      : expanded-key index, registered
module simon_key_index_ctr
  import simon_round_seq_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic                       i_dec,
  input  logic                       i_enc,
  input  simon_mode_e                i_mode,
  output logic                       o_cnt_zero,
  output logic [SIMON_KEY_IDX_W-1:0] o_key_idx
);

  logic [SIMON_KEY_IDX_W-1:0] r_cnt;
  logic [SIMON_KEY_IDX_W-1:0] r_last;
  logic [SIMON_KEY_IDX_W-1:0] r_idx;
  logic                       r_enc;
  logic                       r_zero;

  logic [SIMON_KEY_IDX_W-1:0] w_cnt_nxt;
  logic [SIMON_KEY_IDX_W-1:0] w_last_nxt;
  logic [SIMON_KEY_IDX_W-1:0] w_idx_nxt;
  logic                       w_enc_nxt;

  // Next counter; the index is derived from the next counter so it is valid
  // in the same cycle the round is issued.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    w_enc_nxt  = r_enc;
    if (i_load) begin
      w_last_nxt = simon_last_round(i_mode);
      w_cnt_nxt  = w_last_nxt;
      w_enc_nxt  = i_enc;
    end else if (i_dec && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - SIMON_KEY_IDX_W'(1);
    end
    w_idx_nxt = w_enc_nxt ? (w_last_nxt - w_cnt_nxt) : w_cnt_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= '0;
      r_idx  <= '0;
      r_enc  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_last <= w_last_nxt;
      r_idx  <= w_idx_nxt;
      r_enc  <= w_enc_nxt;
      r_zero <= (w_cnt_nxt == '0);
    end
  end

  assign o_cnt_zero = r_zero;
  assign o_key_idx  = r_idx;

endmodule

// File: rtl/simon_round_seq.sv
// SIMON round sequencer: key-load handshake with an external key expander,
// block acceptance, one round-unit transaction per round, result pulse.
// Optional: SIMON_ROUND_SEQ_TIMEOUT_EN adds io_error and a 5-bit watchdog on
// KWAIT/WAIT that aborts to NOKEY after 31 cycles without a response.
// Ports:
//   clock, reset                  : clock, async active-high reset
//   io_mode                       : 0 = 64/128 (44 rounds), 1 = 128/128 (68 rounds)
//   io_keyValid / io_keyReady     : key-load handshake
//   io_dataValid / io_dataReady   : block-request handshake
//   io_encDec                     : 1 = encrypt, 0 = decrypt
//   io_block1In/2In               : input words
//   io_block1Out/2Out, io_outValid: result and one-cycle valid
//   io_kexpKValid/KReady/ExpValid : key expander control
//   io_rnd*                       : round unit control and data
//   io_keyIdx                     : expanded-key index for the round unit
//   io_busy                       : high outside READY and NOKEY
//   io_error (optional)           : sticky watchdog timeout flag
module simon_round_seq
  import simon_round_seq_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_mode,
  input  logic                       io_keyValid,
  output logic                       io_keyReady,
  input  logic                       io_dataValid,
  output logic                       io_dataReady,
  input  logic                       io_encDec,
  input  logic [SIMON_WORD_W-1:0]    io_block1In,
  input  logic [SIMON_WORD_W-1:0]    io_block2In,
  output logic [SIMON_WORD_W-1:0]    io_block1Out,
  output logic [SIMON_WORD_W-1:0]    io_block2Out,
  output logic                       io_outValid,
  output logic                       io_kexpKValid,
  input  logic                       io_kexpKReady,
  input  logic                       io_kexpExpValid,
  output logic                       io_rndIValid,
  input  logic                       io_rndOValid,
  output logic                       io_rndEncDec,
  output logic [SIMON_WORD_W-1:0]    io_rndBlock1,
  output logic [SIMON_WORD_W-1:0]    io_rndBlock2,
  input  logic [SIMON_WORD_W-1:0]    io_rndBlock1In,
  input  logic [SIMON_WORD_W-1:0]    io_rndBlock2In,
  output logic [SIMON_KEY_IDX_W-1:0] io_keyIdx,
  output logic                       io_busy
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
  ,
  output logic                       io_error
`endif
);

  seq_state_e   r_state;
  seq_state_e   w_state_nxt;
  simon_mode_e  r_mode;
  simon_block_t r_work;
  logic         r_enc;

  logic r_key_ready;
  logic r_data_ready;
  logic r_kexp_kvalid;
  logic r_rnd_ivalid;
  logic r_out_valid;
  logic r_busy;

  logic w_key_acc;
  logic w_blk_acc;
  logic w_capture;
  logic w_dec;
  logic w_cnt_zero;
  logic w_key_ready_nxt;
  logic w_data_ready_nxt;
  logic w_kexp_kvalid_nxt;
  logic w_rnd_ivalid_nxt;
  logic w_out_valid_nxt;
  logic w_busy_nxt;

`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
  logic [SIMON_WD_W-1:0] r_wd;
  logic                  r_error;
  logic                  w_timeout;
`endif

  // Next state, handshake strobes and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_key_acc   = 1'b0;
    w_blk_acc   = 1'b0;
    w_capture   = 1'b0;
    w_dec       = 1'b0;
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_NOKEY: begin
        if (io_keyValid) begin
          w_key_acc   = 1'b1;
          w_state_nxt = ST_KREQ;
        end
      end
      ST_KREQ: begin
        if (io_kexpKReady) w_state_nxt = ST_KWAIT;
      end
      ST_KWAIT: begin
        if (io_kexpExpValid) begin
          w_state_nxt = ST_READY;
        end
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
        else if (r_wd == SIMON_WD_LIMIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_NOKEY;
        end
`endif
      end
      ST_READY: begin
        // A key load takes priority over a block request.
        if (io_keyValid) begin
          w_key_acc   = 1'b1;
          w_state_nxt = ST_KREQ;
        end else if (io_dataValid) begin
          w_blk_acc   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_rndOValid) begin
          w_capture = 1'b1;
          if (w_cnt_zero) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_dec       = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
        else if (r_wd == SIMON_WD_LIMIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_NOKEY;
        end
`endif
      end
      ST_DONE: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_NOKEY;
      end
    endcase

    w_key_ready_nxt   = (w_state_nxt == ST_NOKEY) || (w_state_nxt == ST_READY);
    w_data_ready_nxt  = (w_state_nxt == ST_READY);
    w_kexp_kvalid_nxt = (w_state_nxt == ST_KREQ);
    w_rnd_ivalid_nxt  = (w_state_nxt == ST_ISSUE);
    w_out_valid_nxt   = (w_state_nxt == ST_DONE);
    w_busy_nxt        = !w_key_ready_nxt;
  end

  // State, latched mode/direction, working block and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_NOKEY;
      r_mode        <= SIMON_MODE_64_128;
      r_work        <= '0;
      r_enc         <= 1'b0;
      r_key_ready   <= 1'b1;
      r_data_ready  <= 1'b0;
      r_kexp_kvalid <= 1'b0;
      r_rnd_ivalid  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key_ready   <= w_key_ready_nxt;
      r_data_ready  <= w_data_ready_nxt;
      r_kexp_kvalid <= w_kexp_kvalid_nxt;
      r_rnd_ivalid  <= w_rnd_ivalid_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_busy        <= w_busy_nxt;
      if (w_key_acc) r_mode <= simon_mode_e'(io_mode);
      if (w_blk_acc) begin
        r_work.b1 <= io_block1In;
        r_work.b2 <= io_block2In;
        r_enc     <= io_encDec;
      end else if (w_capture) begin
        r_work.b1 <= io_rndBlock1In;
        r_work.b2 <= io_rndBlock2In;
      end
    end
  end

`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
  // Watchdog restarts on every entry to a waiting state; error is sticky
  // until the next accepted key load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else begin
      if (((w_state_nxt == ST_WAIT) && (r_state != ST_WAIT)) ||
          ((w_state_nxt == ST_KWAIT) && (r_state != ST_KWAIT))) begin
        r_wd <= '0;
      end else if ((r_state == ST_WAIT) || (r_state == ST_KWAIT)) begin
        r_wd <= r_wd + SIMON_WD_W'(1);
      end
      if (w_key_acc) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign io_error = r_error;
`endif

  simon_key_index_ctr u_key_idx (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_blk_acc),
    .i_dec      (w_dec),
    .i_enc      (io_encDec),
    .i_mode     (r_mode),
    .o_cnt_zero (w_cnt_zero),
    .o_key_idx  (io_keyIdx)
  );

  assign io_keyReady   = r_key_ready;
  assign io_dataReady  = r_data_ready;
  assign io_kexpKValid = r_kexp_kvalid;
  assign io_rndIValid  = r_rnd_ivalid;
  assign io_outValid   = r_out_valid;
  assign io_busy       = r_busy;
  assign io_rndEncDec  = r_enc;
  assign io_rndBlock1  = r_work.b1;
  assign io_rndBlock2  = r_work.b2;
  assign io_block1Out  = r_work.b1;
  assign io_block2Out  = r_work.b2;

endmodule

// File: tb/tb_simon_round_seq.sv
// Directed bench for simon_round_seq with a latency-2 stub round unit.
module tb_simon_round_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_mode, io_keyValid, io_keyReady, io_dataValid, io_dataReady;
  logic        io_encDec, io_outValid, io_kexpKValid, io_kexpKReady, io_kexpExpValid;
  logic        io_rndIValid, io_rndOValid, io_rndEncDec, io_busy;
  logic [63:0] io_block1In, io_block2In, io_block1Out, io_block2Out;
  logic [63:0] io_rndBlock1, io_rndBlock2, io_rndBlock1In, io_rndBlock2In;
  logic [6:0]  io_keyIdx;
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
  logic        io_error;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  simon_round_seq dut (
    .clock(clock), .reset(reset), .io_mode(io_mode),
    .io_keyValid(io_keyValid), .io_keyReady(io_keyReady),
    .io_dataValid(io_dataValid), .io_dataReady(io_dataReady),
    .io_encDec(io_encDec), .io_block1In(io_block1In), .io_block2In(io_block2In),
    .io_block1Out(io_block1Out), .io_block2Out(io_block2Out), .io_outValid(io_outValid),
    .io_kexpKValid(io_kexpKValid), .io_kexpKReady(io_kexpKReady),
    .io_kexpExpValid(io_kexpExpValid), .io_rndIValid(io_rndIValid),
    .io_rndOValid(io_rndOValid), .io_rndEncDec(io_rndEncDec),
    .io_rndBlock1(io_rndBlock1), .io_rndBlock2(io_rndBlock2),
    .io_rndBlock1In(io_rndBlock1In), .io_rndBlock2In(io_rndBlock2In),
    .io_keyIdx(io_keyIdx), .io_busy(io_busy)
`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
    , .io_error(io_error)
`endif
  );

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [63:0] f_simon(input logic [63:0] x);
    return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
  endfunction

  // Stand-in for expanded[idx].
  function automatic logic [63:0] rkey(input logic [6:0] i);
    return {8{1'b0, i}} ^ 64'h0f1e_2d3c_4b5a_6978;
  endfunction

  function automatic logic [127:0] stub_round(input logic [63:0] a, input logic [63:0] b,
                                              input logic enc, input logic [6:0] idx);
    if (enc) return {b ^ f_simon(a) ^ rkey(idx), a};
    return {b, a ^ f_simon(b) ^ rkey(idx)};
  endfunction

  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic enc, input int r_cnt);
    logic [127:0] v;
    v = {a, b};
    for (int r = 0; r < r_cnt; r++)
      v = stub_round(v[127:64], v[63:0], enc, 7'(enc ? r : (r_cnt - 1 - r)));
    return v;
  endfunction

  // Latency-2 stub round unit; stub_hold withholds the response.
  logic        s1_v, s2_v, stub_hold;
  logic [63:0] s1_a, s1_b, s2_a, s2_b;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0; s2_v <= 1'b0;
      s1_a <= '0; s1_b <= '0; s2_a <= '0; s2_b <= '0;
    end else begin
      s1_v <= io_rndIValid;
      if (io_rndIValid) {s1_a, s1_b} <= stub_round(io_rndBlock1, io_rndBlock2, io_rndEncDec, io_keyIdx);
      s2_v <= s1_v; s2_a <= s1_a; s2_b <= s1_b;
    end
  end
  assign io_rndOValid   = s2_v & ~stub_hold;
  assign io_rndBlock1In = s2_a;
  assign io_rndBlock2In = s2_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic mode, input logic with_data);
    @(negedge clock);
    check("key_ready", 64'(io_keyReady), 64'd1);
    io_mode = mode; io_keyValid = 1'b1; io_dataValid = with_data;
    @(negedge clock);
    io_keyValid = 1'b0; io_dataValid = 1'b0;
    check("kreq_kvalid", 64'(io_kexpKValid), 64'd1);
    check("kreq_no_issue", 64'(io_rndIValid), 64'd0);
    check("kreq_busy", 64'(io_busy), 64'd1);
    @(negedge clock);
    check("kwait_kvalid_low", 64'(io_kexpKValid), 64'd0);
    repeat (4) @(negedge clock);
    io_kexpExpValid = 1'b1;
    @(negedge clock);
    io_kexpExpValid = 1'b0;
    check("ready_dready", 64'(io_dataReady), 64'd1);
    check("ready_busy", 64'(io_busy), 64'd0);
  endtask

  // Runs one block; abort_at > 0 stops at that issue pulse without checks.
  task automatic run_block(input logic [63:0] b1, input logic [63:0] b2, input logic enc,
                           input int r_cnt, input int abort_at, input logic disturb,
                           output logic [63:0] o1, output logic [63:0] o2);
    int cyc, pulses, out_cyc, idx_bad, enc_bad, kv_seen;
    logic [127:0] exp_v;
    cyc = 1; pulses = 0; out_cyc = 0; idx_bad = 0; enc_bad = 0; kv_seen = 0;
    o1 = '0; o2 = '0;
    @(negedge clock);
    check("blk_dready", 64'(io_dataReady), 64'd1);
    io_block1In = b1; io_block2In = b2; io_encDec = enc; io_dataValid = 1'b1;
    while (cyc < 1000) begin
      @(negedge clock);
      cyc++;
      io_dataValid = 1'b0;
      if (disturb) begin io_keyValid = 1'b1; io_mode = cyc[0]; end
      if (io_kexpKValid) kv_seen++;
      if (io_rndIValid) begin
        if (io_keyIdx != 7'(enc ? pulses : (r_cnt - 1 - pulses))) idx_bad++;
        if (io_rndEncDec != enc) enc_bad++;
        pulses++;
        if (pulses == abort_at) break;
      end
      if (io_outValid) begin
        out_cyc = cyc; o1 = io_block1Out; o2 = io_block2Out;
        break;
      end
    end
    io_keyValid = 1'b0;
    if (abort_at == 0) begin
      exp_v = model(b1, b2, enc, r_cnt);
      check("pulses", 64'(pulses), 64'(r_cnt));
      check("keyidx_seq_errs", 64'(idx_bad), 64'd0);
      check("encdec_errs", 64'(enc_bad), 64'd0);
      check("outvalid_cycle", 64'(out_cyc), 64'(r_cnt * 3 + 2));
      check("blk1_out", o1, exp_v[127:64]);
      check("blk2_out", o2, exp_v[63:0]);
      check("kexp_during_blk", 64'(kv_seen), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_keyready"}, 64'(io_keyReady), 64'd1);
    check({tag, "_dataready"}, 64'(io_dataReady), 64'd0);
    check({tag, "_busy"}, 64'(io_busy), 64'd0);
    check({tag, "_kvalid"}, 64'(io_kexpKValid), 64'd0);
    check({tag, "_ivalid"}, 64'(io_rndIValid), 64'd0);
    check({tag, "_outvalid"}, 64'(io_outValid), 64'd0);
    check({tag, "_keyidx"}, 64'(io_keyIdx), 64'd0);
    check({tag, "_rndblk1"}, io_rndBlock1, 64'd0);
    check({tag, "_blk2out"}, io_block2Out, 64'd0);
  endtask

  logic [63:0] ct1, ct2, r1, r2;
  int          seen;

  initial begin
    reset = 1'b1; io_mode = 1'b0; io_keyValid = 1'b0; io_dataValid = 1'b0;
    io_encDec = 1'b0; io_block1In = '0; io_block2In = '0;
    io_kexpKReady = 1'b1; io_kexpExpValid = 1'b0; stub_hold = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
    reset = 1'b0;

    // Block request without a key is ignored.
    @(negedge clock);
    io_dataValid = 1'b1;
    @(negedge clock);
    io_dataValid = 1'b0;
    check("nokey_no_issue", 64'(io_rndIValid), 64'd0);
    check("nokey_busy", 64'(io_busy), 64'd0);

    // Mode 0: encrypt, then decrypt the ciphertext back to the plaintext.
    load_key(1'b0, 1'b0);
    run_block(64'h0302_0100, 64'h0706_0504, 1'b1, 44, 0, 1'b0, ct1, ct2);
    run_block(ct1, ct2, 1'b0, 44, 0, 1'b0, r1, r2);
    check("rt44_blk1", r1, 64'h0302_0100);
    check("rt44_blk2", r2, 64'h0706_0504);

    // Mode 1 loaded with a simultaneous block request (key wins).
    load_key(1'b1, 1'b1);
    run_block(64'hdead_beef_0bad_f00d, 64'h1234_5678_9abc_def0, 1'b0, 68, 0, 1'b0, ct1, ct2);
    run_block(ct1, ct2, 1'b1, 68, 0, 1'b0, r1, r2);
    check("rt68_blk1", r1, 64'hdead_beef_0bad_f00d);
    check("rt68_blk2", r2, 64'h1234_5678_9abc_def0);

    // Key requests and mode toggling mid-block are ignored.
    load_key(1'b0, 1'b0);
    run_block(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1, 44, 0, 1'b1, r1, r2);

    // Reset during round 20 discards block and key.
    run_block(64'haaaa_0000_5555_ffff, 64'h0f0f_f0f0_3c3c_c3c3, 1'b1, 44, 20, 1'b0, r1, r2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b0;
    io_dataValid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (io_rndIValid || io_dataReady) seen++;
    end
    io_dataValid = 1'b0;
    check("postrst_no_block", 64'(seen), 64'd0);
    load_key(1'b0, 1'b0);
    run_block(64'h0302_0100, 64'h0706_0504, 1'b1, 44, 0, 1'b0, r1, r2);

`ifdef SIMON_ROUND_SEQ_TIMEOUT_EN
    // Withheld round response trips the watchdog.
    check("err_clear", 64'(io_error), 64'd0);
    stub_hold = 1'b1;
    @(negedge clock);
    io_block1In = 64'h1; io_block2In = 64'h2; io_encDec = 1'b1; io_dataValid = 1'b1;
    seen = 1;
    while (!io_error && seen < 100) begin
      @(negedge clock);
      io_dataValid = 1'b0;
      seen++;
    end
    check("err_cycle", 64'(seen), 64'd34);
    check("err_keyready", 64'(io_keyReady), 64'd1);
    check("err_busy", 64'(io_busy), 64'd0);
    repeat (3) @(negedge clock);
    check("err_sticky", 64'(io_error), 64'd1);
    stub_hold = 1'b0;
    load_key(1'b0, 1'b0);
    check("err_cleared_by_key", 64'(io_error), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule

// File: doc/simon_round_seq.md
SIMON_ROUND_SEQ -- requirements
Module: simon_round_seq

Interface
REQ-001 SHALL provide: clock  in  1  single clock; all state on its rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: io_mode  in  1  0 = SIMON 64/128 (44 rounds), 1 = SIMON 128/128 (68 rounds); sampled only at key load.
REQ-004 SHALL provide: io_keyValid  in  1 / io_keyReady  out  1  key-load handshake.
REQ-005 SHALL provide: io_dataValid  in  1 / io_dataReady  out  1  block-request handshake.
REQ-006 SHALL provide: io_encDec  in  1  1 = encrypt, 0 = decrypt; sampled with the block.
REQ-007 SHALL provide: io_block1In, io_block2In  in  64  plaintext/ciphertext words.
REQ-008 SHALL provide: io_block1Out, io_block2Out  out  64 / io_outValid  out  1  result, one-cycle valid pulse.
REQ-009 SHALL provide: io_kexpKValid  out  1, io_kexpKReady  in  1, io_kexpExpValid  in  1  key expander control.
REQ-010 SHALL provide: io_rndIValid  out  1, io_rndOValid  in  1, io_rndEncDec  out  1, io_rndBlock1/2  out  64, io_rndBlock1In/2In  in  64  round unit control and data.
REQ-011 SHALL provide: io_keyIdx  out  7  expanded-key index; the top level muxes expanded[io_keyIdx] onto the round unit's roundKey.
REQ-012 SHALL provide: io_busy  out  1  high in every state except READY and NOKEY.

Function
REQ-013 SHALL use the states NOKEY, KREQ, KWAIT, READY, ISSUE, WAIT, DONE.
REQ-014 io_keyReady SHALL be high in NOKEY and READY only; io_keyValid&&io_keyReady SHALL latch io_mode and enter KREQ.
REQ-015 KREQ SHALL hold io_kexpKValid high until io_kexpKReady is seen, then pulse it low and enter KWAIT.
REQ-016 KWAIT SHALL enter READY on io_kexpExpValid; io_dataReady SHALL be high only in READY.
REQ-017 In READY, io_dataValid SHALL latch both blocks and io_encDec, load the round counter with R-1 (R = 44 or 68), and enter ISSUE; a simultaneous io_keyValid SHALL win over io_dataValid.
REQ-018 ISSUE SHALL assert io_rndIValid for exactly one cycle with io_rndBlock1/2 = the working registers, then enter WAIT.
REQ-019 io_keyIdx SHALL be (R-1-counter) for encrypt and counter for decrypt, stable from ISSUE until io_rndOValid.
REQ-020 In WAIT, io_rndOValid SHALL capture io_rndBlock1In/2In into the working registers; if counter==0 go DONE, else decrement and go ISSUE.
REQ-021 DONE SHALL drive io_outValid for one cycle with the working registers on io_block1Out/2Out, then return to READY.
REQ-022 Throughput SHALL be R*(L+1)+2 cycles per block for a round unit of latency L (>= 1).
REQ-023 io_keyValid and io_dataValid outside the accepting states SHALL be ignored; the latched mode SHALL never change mid-block.
REQ-024 io_rndOValid outside WAIT SHALL be ignored.

Reset
REQ-025 Reset SHALL force NOKEY, counter 0, working registers 0, io_keyIdx 0 and every output valid/ready/busy low except io_keyReady, which is high.
REQ-026 Reset asserted mid-block SHALL discard the block and the key; a new key load SHALL be required.

Configuration
REQ-027 With SIMON_ROUND_SEQ_TIMEOUT_EN defined, the block SHALL add io_error (out, 1) and a 5-bit watchdog.
REQ-028 The watchdog SHALL clear on entering WAIT or KWAIT; 31 cycles without a response SHALL set io_error (sticky until the next key load) and enter NOKEY.
REQ-029 Without the macro, io_error and the watchdog SHALL be absent and WAIT/KWAIT SHALL wait indefinitely.

Structure
REQ-030 The state encoding, the round counts 44/68 and the mode encoding SHALL live in the shared SIMON package/header, next to the existing SIMON mode and round constants.
REQ-031 The round-count/key-index generator SHALL be one sub-module, simon_key_index_ctr; all other logic SHALL be flat.

Verification
REQ-032 The bench SHALL cover these scenarios, using a stub round unit with L = 2:
- Key load with mode = 0 and io_kexpKReady high: io_kexpKValid high for 1 cycle, then io_kexpExpValid raised after 5 cycles -> io_dataReady = 1 in the next cycle.
- Encrypt, mode = 0, blocks 0x03020100/0x07060504: io_keyIdx sequence 0..43, 44 io_rndIValid pulses, io_outValid at cycle 134 after acceptance, outputs equal the round unit's final output.
- Decrypt, mode = 1: io_keyIdx sequence 67..0, 68 pulses, io_rndEncDec = 0 throughout.
- Key load requested while busy: io_keyValid asserted in WAIT is ignored; io_mode toggled mid-block leaves the round count unchanged.
- Reset asserted during round 20: all outputs return to reset values next cycle, io_keyReady = 1, io_dataReady = 0.
- SIMON_ROUND_SEQ_TIMEOUT_EN defined and io_rndOValid withheld: io_error = 1 after 31 WAIT cycles, state NOKEY; the next key load clears io_error.
